// File: rtl/freq_pkg.sv
// Shared types, note table and constant helpers for the frequency-entry controller.
package freq_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {LD_IDLE, LD_SCALE, LD_DABBLE, LD_WRITE} ld_state_t;
  typedef enum logic {REB_IDLE, REB_RUN} reb_state_t;

  localparam int NOTE_CNT      = 12;
  localparam int DABBLE_CYCLES = 32;

  // Octave-4 chromatic notes in dHz, index 0 = C.
  localparam logic [NOTE_CNT-1:0][13:0] NOTE_TBL = {
    14'd4939, 14'd4662, 14'd4400, 14'd4153, 14'd3920, 14'd3700,
    14'd3492, 14'd3296, 14'd3111, 14'd2937, 14'd2772, 14'd2616
  };

  function automatic logic [63:0] to_bcd64(input logic [63:0] v);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(t % 64'd10);
      t = t / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble, one input bit per cycle; first bit is taken on the start edge.
// done pulses for one cycle after the 32nd bit; bcd holds its value until the next start.
module bin2bcd_seq
  import freq_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  logic [31:0] sh;
  logic [4:0]  cnt;
  logic        run;

  function automatic logic [4*DIGITS-1:0] dabble(input logic [4*DIGITS-1:0] b,
                                                 input logic bit_in);
    logic [4*DIGITS-1:0] a;
    for (int i = 0; i < DIGITS; i++) begin
      a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {a[4*DIGITS-2:0], bit_in};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd <= dabble('0, bin[31]);
        sh  <= {bin[30:0], 1'b0};
        cnt <= 5'(DABBLE_CYCLES - 1);
        run <= 1'b1;
      end else if (run) begin
        bcd <= dabble(bcd, sh[31]);
        sh  <= {sh[30:0], 1'b0};
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_entry_ctrl.sv
// BCD frequency editor and note/octave loader; digit steps rebuild f_dHz over DIGITS cycles,
// note loads hold busy for 34 cycles. Define AUTO_REPEAT_EN for held up/down repeat.
module freq_entry_ctrl
  import freq_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int OCT_W        = 3,
  parameter int REPEAT_TICKS = 20_000_000,
  parameter int RST_DHZ      = 2616
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_mode,
  input  logic                        btn_left,
  input  logic                        btn_right,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        note_valid,
  input  logic [3:0]                  note_idx,
  input  logic [OCT_W-1:0]            octave,
  output logic [4*DIGITS-1:0]         digits,
  output logic [31:0]                 f_dHz,
  output logic                        f_valid,
  output logic                        busy,
  output logic                        edit_mode,
  output logic [$clog2(DIGITS)-1:0]   cursor,
  output logic                        blink_ena
);

  localparam int          CW        = $clog2(DIGITS);
  localparam logic [63:0] RST_BCD64 = to_bcd64(64'(RST_DHZ));
  localparam logic [63:0] MAX_DHZ   = pow10(DIGITS) - 64'd1;

  logic [4:0]          btn_q;
  logic                mode_rise, left_rise, right_rise, up_rise, down_rise;
  logic                up_rpt, down_rpt;
  logic                ed_ok, up_go, down_go, step;
  bcd_digit_t          cur_d, new_d;

  ld_state_t           ld_state, ld_next;
  reb_state_t          reb_state, reb_next;
  logic                ld_trig, reb_done;
  logic [3:0]          ld_idx, last_idx;
  logic [OCT_W-1:0]    ld_oct, last_oct;
  logic                last_vld;
  logic [CW-1:0]       reb_idx;
  logic [31:0]         acc, acc_next;
  logic [63:0]         shifted;
  logic [31:0]         scaled;
  int                  oct_i;
  logic                conv_start, conv_done;
  logic [4*DIGITS-1:0] conv_bcd;

  assign {mode_rise, left_rise, right_rise, up_rise, down_rise} =
         {btn_mode, btn_left, btn_right, btn_up, btn_down} & ~btn_q;

  assign busy      = (ld_state != LD_IDLE);
  assign blink_ena = edit_mode & ~(btn_left | btn_right | btn_up | btn_down);
  assign ed_ok     = edit_mode & ~busy;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] up_cnt, down_cnt;

  assign up_rpt   = btn_up   & ~up_rise   & (up_cnt   == RW'(REPEAT_TICKS - 1));
  assign down_rpt = btn_down & ~down_rise & (down_cnt == RW'(REPEAT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else begin
      up_cnt   <= (!btn_up   || up_rise   || up_rpt)   ? '0 : up_cnt + RW'(1);
      down_cnt <= (!btn_down || down_rise || down_rpt) ? '0 : down_cnt + RW'(1);
    end
  end
`else
  assign up_rpt   = 1'b0;
  assign down_rpt = 1'b0;
`endif

  // Holding the opposite button vetoes a step, including on a simultaneous press.
  assign up_go   = ed_ok & (up_rise | up_rpt) & ~btn_down;
  assign down_go = ed_ok & (down_rise | down_rpt) & ~btn_up;
  assign step    = up_go | down_go;

  always_comb begin
    cur_d = digits[4*cursor +: 4];
    new_d = cur_d;
    if (up_go)        new_d = (cur_d == 4'd9) ? 4'd0 : cur_d + 4'd1;
    else if (down_go) new_d = (cur_d == 4'd0) ? 4'd9 : cur_d - 4'd1;
  end

  assign ld_trig = (ld_state == LD_IDLE) && note_valid && (note_idx < 4'(NOTE_CNT)) &&
                   (!last_vld || {note_idx, octave} != {last_idx, last_oct});

  always_comb begin
    oct_i   = int'($signed(ld_oct));
    shifted = 64'(NOTE_TBL[ld_idx]);
    if (oct_i >= 0) shifted = shifted << oct_i;
    else            shifted = shifted >> (-oct_i);
    scaled = (shifted > MAX_DHZ) ? MAX_DHZ[31:0] : shifted[31:0];
  end

  assign conv_start = (ld_state == LD_SCALE);

  bin2bcd_seq #(.DIGITS(DIGITS)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (scaled),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_IDLE:   if (ld_trig) ld_next = LD_SCALE;
      LD_SCALE:  ld_next = LD_DABBLE;
      LD_DABBLE: if (conv_done) ld_next = LD_WRITE;
      LD_WRITE:  ld_next = LD_IDLE;
      default:   ld_next = LD_IDLE;
    endcase
  end

  assign acc_next = acc * 32'd10 + 32'(digits[4*reb_idx +: 4]);
  assign reb_done = (reb_state == REB_RUN) && !step && !ld_trig && (reb_idx == '0);

  always_comb begin
    reb_next = reb_state;
    case (reb_state)
      REB_IDLE: if (step && !ld_trig) reb_next = REB_RUN;
      REB_RUN: begin
        if (ld_trig)       reb_next = REB_IDLE;
        else if (step)     reb_next = REB_RUN;
        else if (reb_done) reb_next = REB_IDLE;
      end
      default: reb_next = REB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state  <= LD_IDLE;
      reb_state <= REB_IDLE;
    end else begin
      ld_state  <= ld_next;
      reb_state <= reb_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= '0;
      edit_mode <= 1'b0;
      cursor    <= '0;
      digits    <= RST_BCD64[4*DIGITS-1:0];
      f_dHz     <= 32'(RST_DHZ);
      f_valid   <= 1'b1;
      acc       <= '0;
      reb_idx   <= '0;
      ld_idx    <= '0;
      ld_oct    <= '0;
      last_idx  <= '0;
      last_oct  <= '0;
      last_vld  <= 1'b0;
    end else begin
      btn_q <= {btn_mode, btn_left, btn_right, btn_up, btn_down};

      if (mode_rise) edit_mode <= ~edit_mode;

      if (ed_ok && left_rise && !right_rise)
        cursor <= (cursor == CW'(DIGITS - 1)) ? '0 : cursor + CW'(1);
      else if (ed_ok && right_rise && !left_rise)
        cursor <= (cursor == '0) ? CW'(DIGITS - 1) : cursor - CW'(1);

      if (step) begin
        digits[4*cursor +: 4] <= new_d;
        acc     <= '0;
        reb_idx <= CW'(DIGITS - 1);
      end else if (reb_state == REB_RUN) begin
        acc     <= acc_next;
        reb_idx <= reb_idx - CW'(1);
      end

      if (ld_state == LD_WRITE) begin
        digits   <= conv_bcd;
        f_dHz    <= scaled;
        f_valid  <= 1'b1;
        last_idx <= ld_idx;
        last_oct <= ld_oct;
        last_vld <= 1'b1;
      end else if (step) begin
        f_valid <= 1'b0;
      end else if (reb_done) begin
        f_dHz   <= acc_next;
        f_valid <= 1'b1;
      end

      if (ld_trig) begin
        ld_idx <= note_idx;
        ld_oct <= octave;
      end
    end
  end

endmodule

// File: tb/tb_freq_entry_ctrl.sv
// Scoreboard bench: stimulus updates a digit-array model and queues expected f_dHz/digits updates.
module tb_freq_entry_ctrl;
  localparam int DIGITS = 4, OCT_W = 3, REPEAT_TICKS = 10, RST_DHZ = 2616;
  localparam int MAXV = 9999, LOAD_BUSY = 34;

  logic clk = 1'b0;
  logic rst;
  logic btn_mode, btn_left, btn_right, btn_up, btn_down;
  logic note_valid;
  logic [3:0] note_idx;
  logic [OCT_W-1:0] octave;
  logic [4*DIGITS-1:0] digits;
  logic [31:0] f_dHz;
  logic f_valid, busy, edit_mode, blink_ena;
  logic [$clog2(DIGITS)-1:0] cursor;

  always #5 clk = ~clk;

  freq_entry_ctrl #(.DIGITS(DIGITS), .OCT_W(OCT_W), .REPEAT_TICKS(REPEAT_TICKS),
                    .RST_DHZ(RST_DHZ)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_left(btn_left),
    .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .note_valid(note_valid), .note_idx(note_idx), .octave(octave),
    .digits(digits), .f_dHz(f_dHz), .f_valid(f_valid), .busy(busy),
    .edit_mode(edit_mode), .cursor(cursor), .blink_ena(blink_ena));

  typedef struct {
    bit          is_load;
    int          value;
    logic [15:0] bcd;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  int m_d[DIGITS];
  bit m_edit;
  int m_cur;
  bit m_last_vld;
  int m_last_idx, m_last_oct;
  int base_tbl[12] = '{2616, 2772, 2937, 3111, 3296, 3492, 3700, 3920, 4153, 4400, 4662, 4939};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_val();
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + m_d[i];
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    int t = RST_DHZ;
    for (int i = 0; i < DIGITS; i++) begin
      m_d[i] = t % 10;
      t = t / 10;
    end
    m_edit = 0;
    m_cur = 0;
    m_last_vld = 0;
  endfunction

  // Monitor: each load completion (busy fall) or rebuild completion (f_valid rise) pops one entry.
  bit prev_busy = 0, prev_fv = 1;
  int busy_len = 0, low_len = 0;

  task automatic pop_check(input bit is_load);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_update: got f_dHz=%0d digits=0x%0h with nothing expected",
               f_dHz, digits);
    end else begin
      e = exp_q.pop_front();
      check("update_kind", 64'(is_load), 64'(e.is_load));
      check("f_dHz", 64'(f_dHz), 64'(e.value));
      check("digits", 64'(digits), 64'(e.bcd));
      check("f_valid_after", 64'(f_valid), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 0;
      prev_fv = 1;
      busy_len = 0;
      low_len = 0;
    end else begin
      if (busy) busy_len++;
      if (!f_valid) low_len++;
      if (prev_busy && !busy) begin
        pop_check(1'b1);
        check("load_busy_cycles", 64'(busy_len), 64'(LOAD_BUSY));
      end else if (!prev_fv && f_valid) begin
        pop_check(1'b0);
        check("rebuild_low_cycles", 64'(low_len), 64'(DIGITS));
      end
      if (!busy) busy_len = 0;
      if (f_valid) low_len = 0;
      prev_busy = busy;
      prev_fv = f_valid;
    end
  end

  // mask = {mode, left, right, up, down}; model effects are applied by the caller.
  task automatic press(input bit [4:0] m, input int hold);
    @(negedge clk);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = m;
    repeat (hold) @(negedge clk);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = 5'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while ((busy || !f_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || !f_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: timed out busy=%0b f_valid=%0b required 0/1", busy, f_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic model_note(input int idx, input int o);
    int v;
    if (idx < 12 && (!m_last_vld || idx != m_last_idx || o != m_last_oct)) begin
      v = (o >= 0) ? (base_tbl[idx] << o) : (base_tbl[idx] >> (-o));
      if (v > MAXV) v = MAXV;
      for (int i = 0; i < DIGITS; i++) m_d[i] = (v / (10 ** i)) % 10;
      exp_q.push_back('{1'b1, v, to_bcd(v)});
      m_last_vld = 1;
      m_last_idx = idx;
      m_last_oct = o;
    end
  endtask

  task automatic drive_note(input int idx, input int o, input int hold);
    model_note(idx, o);
    @(negedge clk);
    note_idx = 4'(idx);
    octave = 3'(o);
    note_valid = 1'b1;
    repeat (hold) @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic do_note(input int idx, input int o, input int hold);
    drive_note(idx, o, hold);
    wait_idle();
  endtask

  task automatic model_step(input bit up, input bit dn);
    if (m_edit && (up ^ dn)) begin
      m_d[m_cur] = up ? (m_d[m_cur] + 1) % 10 : (m_d[m_cur] + 9) % 10;
      exp_q.push_back('{1'b0, model_val(), to_bcd(model_val())});
    end
  endtask

  task automatic do_button(input bit [4:0] m, input int hold);
    if (m[4]) m_edit = !m_edit;
    if (m_edit && m[3] && !m[2]) m_cur = (m_cur + 1) % DIGITS;
    if (m_edit && m[2] && !m[3]) m_cur = (m_cur + DIGITS - 1) % DIGITS;
    model_step(m[1], m[0]);
    press(m, hold);
    wait_idle();
    check("cursor", 64'(cursor), 64'(m_cur));
    check("edit_mode", 64'(edit_mode), 64'(m_edit));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, idx, o, hold;
    rst = 1'b1;
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = 5'b0;
    note_valid = 1'b0;
    note_idx = '0;
    octave = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_digits", 64'(digits), 64'h2616);
    check("rst_f_dHz", 64'(f_dHz), 64'd2616);
    check("rst_f_valid", 64'(f_valid), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cursor", 64'(cursor), 64'd0);
    check("rst_edit_mode", 64'(edit_mode), 64'd0);

    do_note(9, 0, 50);                       // A4 held past busy: exactly one load
    do_note(11, 2, 4);                       // clamps to 9999
    do_note(0, -1, 4);                       // 1308
    do_note(0, 0, 4);                        // back to 2616
    do_button(5'b10000, 2);                  // edit on
    check("blink_ena", 64'(blink_ena), 64'd1);
    do_button(5'b00001, 2);                  // down on digit 6 -> 2615
    do_button(5'b00100, 2);                  // right from 0 wraps to 3
    do_button(5'b01000, 2);                  // left from 3 wraps to 0
    do_note(11, 3, 4);                       // 9999 again
    do_button(5'b00010, 2);                  // 9 -> 0, neighbour untouched -> 9990

    drive_note(2, 0, 3);                     // mode honoured during busy, up dropped
    m_edit = !m_edit;
    press(5'b10000, 2);
    check("mode_during_busy", 64'(edit_mode), 64'(m_edit));
    press(5'b00010, 2);
    check("busy_during_load", 64'(busy), 64'd1);
    wait_idle();

    drive_note(3, 1, 10);                    // reset aborts the load
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_digits", 64'(digits), 64'h2616);
    check("abort_f_dHz", 64'(f_dHz), 64'd2616);
    check("abort_busy", 64'(busy), 64'd0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      hold = $urandom_range(1, 6);
      if (r <= 2) begin
        if (m_last_vld && $urandom_range(0, 2) == 0) begin
          idx = m_last_idx;
          o = m_last_oct;
        end else begin
          idx = $urandom_range(0, 15);
          o = $urandom_range(0, 7);
          if (o >= 4) o = o - 8;
        end
        do_note(idx, o, $urandom_range(2, 5));
      end else if (r == 3) do_button(5'b10000, hold);
      else if (r == 4) do_button(5'b01000, hold);
      else if (r == 5) do_button(5'b00100, hold);
      else if (r <= 7) do_button(5'b00010, hold);
      else if (r == 8) do_button(5'b00001, hold);
      else do_button(5'b00011, hold);
      check("rand_blink", 64'(blink_ena), 64'(m_edit));
    end

`ifdef AUTO_REPEAT_EN
    if (!m_edit) do_button(5'b10000, 2);
    for (int k = 0; k < 4; k++) model_step(1'b1, 1'b0);  // edge + 3 repeats in 35 cycles
    press(5'b00010, 35);
    wait_idle();
    press(5'b00011, 25);
    wait_idle();
    check("repeat_digits", 64'(digits), 64'(to_bcd(model_val())));
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_entry_ctrl.md
Name: freq_entry_ctrl

Overview:
- Parametrised frequency-entry controller for the tone path. Holds an N-digit BCD frequency in deci-hertz (dHz) and drives the harmonic and square tone generators through `f_dHz`.
- Two ways to set the value: button-driven per-digit editing, or loading one of 12 chromatic notes with a signed octave shift.
- Single-clock successor to the earlier display-side editor: everything, including button edge detection, runs on `clk`.
- Adds a sequential binary↔BCD datapath, a saturation ceiling and a busy/valid handshake.

Parameters:
- DIGITS, 8: number of BCD digits; cursor range is 0..DIGITS-1.
- OCT_W, 3: width of the signed octave shift.
- REPEAT_TICKS, 20_000_000: auto-repeat period in `clk` cycles while up/down is held.
- RST_DHZ, 2616: frequency loaded at reset (C4, 261.6 Hz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  debounced level; toggles edit mode on each rising edge
- btn_left  in  1  debounced level; cursor +1 (toward MSD) on each rising edge
- btn_right  in  1  debounced level; cursor -1 on each rising edge
- btn_up  in  1  debounced level; increments the digit under the cursor
- btn_down  in  1  debounced level; decrements the digit under the cursor
- note_valid  in  1  level; a note is selected
- note_idx  in  4  chromatic index 0=C .. 11=B; values 12..15 are ignored
- octave  in  OCT_W  signed shift relative to octave 4
- digits  out  4*DIGITS  BCD value; digit 0 is the LSD (tenths of Hz)
- f_dHz  out  32  binary equivalent of `digits`
- f_valid  out  1  high when `f_dHz` matches `digits`
- busy  out  1  note load in progress
- edit_mode  out  1  editor active
- cursor  out  $clog2(DIGITS)  currently selected digit
- blink_ena  out  1  asserted when `edit_mode` is set and none of left/right/up/down is held

Behaviour:
- Reset (async, active-high):
  - `digits` = BCD(RST_DHZ); `f_dHz` = RST_DHZ; `f_valid` = 1.
  - `busy` = 0; `edit_mode` = 0; `cursor` = 0.
  - Repeat counters cleared; the last-loaded note register is set to "none".
  - Reset mid-load or mid-rebuild aborts the operation with no partial write.
- Button handling:
  - Rising edges are detected against a 1-cycle registered copy of each button.
  - Edit actions (left/right/up/down) are accepted only when `edit_mode` = 1 and `busy` = 0; otherwise they are dropped.
  - `btn_mode` is honoured even while `busy` = 1.
- Cursor: wraps modulo DIGITS in both directions (DIGITS-1 +1 → 0; 0 -1 → DIGITS-1).
- Digit step:
  - Up: digit = (d+1) mod 10. Down: digit = (d+9) mod 10.
  - No carry into neighbouring digits.
  - The step happens on the press edge, then once every REPEAT_TICKS cycles while the button stays held.
  - If up and down are both held, neither acts.
- Rebuild FSM (REB_IDLE → REB_RUN):
  - Any digit step sets `f_valid` = 0 and runs a Horner pass over DIGITS cycles, MSD first: acc = acc*10 + d.
  - At completion, `f_dHz` = acc and `f_valid` = 1.
  - A further step during the pass restarts it.
- Load FSM (LD_IDLE → LD_SCALE → LD_DABBLE → LD_WRITE):
  - Trigger: `note_valid` = 1 with {note_idx, octave} different from the last-loaded pair, while idle.
  - LD_SCALE (1 cycle):
    - Base value from the table {2616, 2772, 2937, 3111, 3296, 3492, 3700, 3920, 4153, 4400, 4662, 4939}.
    - Positive `octave`: shift left. Negative `octave`: shift right (truncating).
    - Clamp to 10^DIGITS - 1.
  - LD_DABBLE: 32-cycle shift-add-3 conversion to BCD.
  - LD_WRITE (1 cycle):
    - `digits` and `f_dHz` are written together; `f_valid` = 1; the pair is recorded as last-loaded.
  - Timing: `busy` rises the cycle after the trigger, stays high for 34 cycles, and outputs update on the cycle `busy` falls.
- Simultaneous events and edge cases:
  - If a note change arrives during a load, it is re-evaluated once back in LD_IDLE.
  - A load start cancels any rebuild in progress.
  - `note_valid` falling does not alter `digits`.
  - Re-asserting the same note does not reload.

Optional Feature:
- AUTO_REPEAT_EN
  - Defined: held up/down repeats every REPEAT_TICKS cycles.
  - Undefined: exactly one step per press edge; the repeat counters and REPEAT_TICKS logic are absent.

Decomposition:
- Package `freq_pkg`:
  - note table constant (12×14-bit dHz);
  - load and rebuild state enums;
  - `bcd_digit_t` (4-bit).
- Sub-module `bin2bcd_seq`:
  - iterative double-dabble;
  - start/done handshake;
  - 32-bit input, 4*DIGITS-bit output.

Test Plan:
- Reset → `digits` = 0x00002616, `f_dHz` = 2616, `f_valid` = 1, `busy` = 0, `cursor` = 0.
- note_idx=9, octave=0, note_valid=1 → `busy` high for 34 cycles, then `digits` = 0x00004400, `f_dHz` = 4400; holding the same note → no further `busy`.
- DIGITS=4, note_idx=11, octave=+2 → 4939<<2 = 19756 clamps to 9999; note_idx=0, octave=-1 → 1308.
- `edit_mode` on, cursor 0, press down once on digit 6 → digit 5; `f_valid` low for 8 cycles, then `f_dHz` = 2615.
- Edit mode: press right at cursor 0 → cursor 7; up on a digit holding 9 → 0 with its neighbour unchanged.
- AUTO_REPEAT_EN, REPEAT_TICKS=10: hold up for 35 cycles from digit 0 → 4 steps (edge + 3 repeats); up and down both held → no change.
